// File: rtl/video_encoder_pipe.sv
// video_encoder_pipe
//   Pipelined pixel encoder for the pong display. It maps the scan position
//   (x, y) to a COLOR_W pixel showing two paddles, the ball, a dashed centre
//   net and two-digit scores. Game state is latched once per frame, and the
//   display blinks depending on the game mode. Latency is a fixed 2 cycles.
// Ports
//   clk, rst               pixel clock, asynchronous active-high reset
//   frame_start            1-cycle pulse: latch game state, advance blink count
//   px_valid, x, y         scan position and its valid flag
//   bat_size, mode         paddle height select, game mode
//   p1_score, p2_score     raw scores (display clamps them to 99)
//   p1_y, p2_y             paddle top rows
//   ball_x, ball_y         ball top-left corner
//   px_data_out            pixel, 2 cycles after (x, y)
//   px_valid_out           px_valid delayed by 2 cycles
module video_encoder_pipe #(
    parameter int H_RES    = 640,
    parameter int V_RES    = 480,
    parameter int COORD_W  = 11,
    parameter int SCORE_W  = 6,
    parameter int COLOR_W  = 1,
    parameter int BAT_W    = 8,
    parameter int BAT_H_S  = 48,
    parameter int BAT_H_L  = 96,
    parameter int BALL_SZ  = 8,
    parameter int P1_X     = 16,
    parameter int SCORE_Y  = 16,
    parameter int DIG_SC   = 4,
    parameter int BLINK_FR = 30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic               px_valid,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               bat_size,
    input  logic [1:0]         mode,
    input  logic [SCORE_W-1:0] p1_score,
    input  logic [SCORE_W-1:0] p2_score,
    input  logic [COORD_W-1:0] p1_y,
    input  logic [COORD_W-1:0] p2_y,
    input  logic [COORD_W-1:0] ball_x,
    input  logic [COORD_W-1:0] ball_y,
    output logic [COLOR_W-1:0] px_data_out,
    output logic               px_valid_out
);

    // All range arithmetic is one bit wider than the coordinates so that
    // lo + size can never wrap back onto the screen.
    localparam int CW1 = COORD_W + 1;

    localparam logic [CW1-1:0] H_RES_C  = CW1'(H_RES);
    localparam logic [CW1-1:0] V_RES_C  = CW1'(V_RES);
    localparam logic [CW1-1:0] BAT_W_C  = CW1'(BAT_W);
    localparam logic [CW1-1:0] BAT_S_C  = CW1'(BAT_H_S);
    localparam logic [CW1-1:0] BAT_L_C  = CW1'(BAT_H_L);
    localparam logic [CW1-1:0] BALL_C   = CW1'(BALL_SZ);
    localparam logic [CW1-1:0] P1_X_C   = CW1'(P1_X);
    localparam logic [CW1-1:0] P2_X_C   = CW1'(H_RES - P1_X - BAT_W);
    localparam logic [CW1-1:0] NET_L_C  = CW1'(H_RES / 2 - 1);
    localparam logic [CW1-1:0] NET_R_C  = CW1'(H_RES / 2);
    localparam logic [CW1-1:0] SY_C     = CW1'(SCORE_Y);
    localparam logic [CW1-1:0] DIG_C    = CW1'(DIG_SC);
    localparam logic [CW1-1:0] DW_C     = CW1'(3 * DIG_SC);
    localparam logic [CW1-1:0] DH_C     = CW1'(5 * DIG_SC);
    localparam logic [CW1-1:0] P1T_X_C  = CW1'(H_RES / 2 - 8 * DIG_SC);
    localparam logic [CW1-1:0] P1U_X_C  = CW1'(H_RES / 2 - 4 * DIG_SC);
    localparam logic [CW1-1:0] P2T_X_C  = CW1'(H_RES / 2 + DIG_SC);
    localparam logic [CW1-1:0] P2U_X_C  = CW1'(H_RES / 2 + 5 * DIG_SC);

    localparam logic [COLOR_W-1:0] FG      = {COLOR_W{1'b1}};
    // Net colour is a 0 MSB followed by ones; with a single bit it stays lit.
    localparam logic [COLOR_W-1:0] NET_COL = (COLOR_W == 1) ? FG : (FG >> 1);

    localparam int BLK_W = (BLINK_FR > 1) ? $clog2(BLINK_FR) : 1;
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FR - 1);

    // Half-open range test [lo, lo+sz)
    function automatic logic in_rng(input logic [CW1-1:0] v, lo, sz);
        return (v >= lo) && (v < lo + sz);
    endfunction

    // Segments {a,b,c,d,e,f,g} of a decimal digit
    function automatic logic [6:0] seg_mask(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Pixel test for one digit drawn on a 3x5 cell grid at column x0
    function automatic logic digit_hit(input logic [CW1-1:0] px, py, x0,
                                       input logic [3:0] bcd);
        logic [6:0]     s;
        logic [CW1-1:0] dx;
        logic [CW1-1:0] dy;
        logic [2:0]     col;
        logic [2:0]     row;
        logic           l;
        logic           r;
        logic           hit;
        s   = seg_mask(bcd);
        dx  = px - x0;
        dy  = py - SY_C;
        col = 3'(dx / DIG_C);
        row = 3'(dy / DIG_C);
        l   = (col == 3'd0);
        r   = (col == 3'd2);
        hit = 1'b0;
        if (in_rng(px, x0, DW_C) && in_rng(py, SY_C, DH_C)) begin
            case (row)
                3'd0:    hit = s[6] | (l & s[1]) | (r & s[5]);
                3'd1:    hit = (l & s[1]) | (r & s[5]);
                3'd2:    hit = s[0] | (l & (s[1] | s[2])) | (r & (s[5] | s[4]));
                3'd3:    hit = (l & s[2]) | (r & s[4]);
                3'd4:    hit = s[3] | (l & s[2]) | (r & s[4]);
                default: hit = 1'b0;
            endcase
        end else begin
            hit = 1'b0;
        end
        return hit;
    endfunction

    // Clamp to 99 and split into {tens, units}
    function automatic logic [7:0] to_bcd(input logic [SCORE_W-1:0] sc);
        int v;
        v = int'(sc);
        if (v > 99) begin
            v = 99;
        end else begin
            v = v;
        end
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Shadow game state
    logic [1:0]         mode_d,     mode_q;
    logic               bat_size_d, bat_size_q;
    logic [COORD_W-1:0] p1_y_d,     p1_y_q;
    logic [COORD_W-1:0] p2_y_d,     p2_y_q;
    logic [COORD_W-1:0] ball_x_d,   ball_x_q;
    logic [COORD_W-1:0] ball_y_d,   ball_y_q;
    logic [7:0]         p1_bcd_d,   p1_bcd_q;
    logic [7:0]         p2_bcd_d,   p2_bcd_q;
    // Blink
    logic [BLK_W-1:0]   blk_cnt_d,  blk_cnt_q;
    logic               blink_on_d, blink_on_q;
    // Stage 1
    logic               v1_d, v1_q;
    logic [COORD_W-1:0] x1_d, x1_q;
    logic [COORD_W-1:0] y1_d, y1_q;
    logic               ball1_d, ball1_q;
    logic               bat1_d,  bat1_q;
    logic               bat2_d,  bat2_q;
    logic               score1_d, score1_q;
    logic               net1_d,  net1_q;
    // Stage 2
    logic [COLOR_W-1:0] px_data_d;
    logic               px_valid_d;

    // Shadow load on frame_start and blink counter advance
    always_comb begin
        mode_d     = mode_q;
        bat_size_d = bat_size_q;
        p1_y_d     = p1_y_q;
        p2_y_d     = p2_y_q;
        ball_x_d   = ball_x_q;
        ball_y_d   = ball_y_q;
        p1_bcd_d   = p1_bcd_q;
        p2_bcd_d   = p2_bcd_q;
        blk_cnt_d  = blk_cnt_q;
        blink_on_d = blink_on_q;
        if (frame_start) begin
            mode_d     = mode;
            bat_size_d = bat_size;
            p1_y_d     = p1_y;
            p2_y_d     = p2_y;
            ball_x_d   = ball_x;
            ball_y_d   = ball_y;
            p1_bcd_d   = to_bcd(p1_score);
            p2_bcd_d   = to_bcd(p2_score);
            if (blk_cnt_q == BLK_LAST) begin
                blk_cnt_d  = '0;
                blink_on_d = ~blink_on_q;
            end else begin
                blk_cnt_d  = blk_cnt_q + BLK_W'(1);
                blink_on_d = blink_on_q;
            end
        end else begin
            blk_cnt_d  = blk_cnt_q;
            blink_on_d = blink_on_q;
        end
    end

    // Stage 1: object hit flags, gated by the mode of the latched frame
    always_comb begin
        logic [CW1-1:0] xe;
        logic [CW1-1:0] ye;
        logic [CW1-1:0] bat_h;
        logic           show_ball;
        logic           show_bat;
        logic           show_score;
        logic           show_net;
        logic           hit_score;
        xe    = {1'b0, x};
        ye    = {1'b0, y};
        bat_h = bat_size_q ? BAT_L_C : BAT_S_C;
        case (mode_q)
            2'b00: begin
                show_ball = 1'b0; show_bat = 1'b0; show_score = 1'b1; show_net = 1'b1;
            end
            2'b01: begin
                show_ball = 1'b1; show_bat = 1'b1; show_score = 1'b1; show_net = 1'b1;
            end
            2'b10: begin
                show_ball = blink_on_q; show_bat = 1'b1; show_score = 1'b1; show_net = 1'b1;
            end
            2'b11: begin
                show_ball = 1'b0; show_bat = 1'b1; show_score = blink_on_q; show_net = 1'b1;
            end
            default: begin
                show_ball = 1'b0; show_bat = 1'b0; show_score = 1'b0; show_net = 1'b0;
            end
        endcase
        hit_score = digit_hit(xe, ye, P1T_X_C, p1_bcd_q[7:4])
                  | digit_hit(xe, ye, P1U_X_C, p1_bcd_q[3:0])
                  | digit_hit(xe, ye, P2T_X_C, p2_bcd_q[7:4])
                  | digit_hit(xe, ye, P2U_X_C, p2_bcd_q[3:0]);
        v1_d     = px_valid;
        x1_d     = x;
        y1_d     = y;
        ball1_d  = show_ball & in_rng(xe, {1'b0, ball_x_q}, BALL_C)
                             & in_rng(ye, {1'b0, ball_y_q}, BALL_C);
        bat1_d   = show_bat & in_rng(xe, P1_X_C, BAT_W_C) & in_rng(ye, {1'b0, p1_y_q}, bat_h);
        bat2_d   = show_bat & in_rng(xe, P2_X_C, BAT_W_C) & in_rng(ye, {1'b0, p2_y_q}, bat_h);
        score1_d = show_score & hit_score;
        net1_d   = show_net & ((xe == NET_L_C) || (xe == NET_R_C)) & ~y[3];
    end

    // Stage 2: visibility window and priority mux
    always_comb begin
        px_valid_d = v1_q;
        if (!v1_q || ({1'b0, x1_q} >= H_RES_C) || ({1'b0, y1_q} >= V_RES_C)) begin
            px_data_d = '0;
        end else if (ball1_q) begin
            px_data_d = FG;
        end else if (bat1_q || bat2_q) begin
            px_data_d = FG;
        end else if (score1_q) begin
            px_data_d = FG;
        end else if (net1_q) begin
            px_data_d = NET_COL;
        end else begin
            px_data_d = '0;
        end
    end

    // State and pipeline registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q       <= 2'b00;
            bat_size_q   <= 1'b0;
            p1_y_q       <= '0;
            p2_y_q       <= '0;
            ball_x_q     <= '0;
            ball_y_q     <= '0;
            p1_bcd_q     <= 8'h00;
            p2_bcd_q     <= 8'h00;
            blk_cnt_q    <= '0;
            blink_on_q   <= 1'b1;
            v1_q         <= 1'b0;
            x1_q         <= '0;
            y1_q         <= '0;
            ball1_q      <= 1'b0;
            bat1_q       <= 1'b0;
            bat2_q       <= 1'b0;
            score1_q     <= 1'b0;
            net1_q       <= 1'b0;
            px_data_out  <= '0;
            px_valid_out <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            bat_size_q   <= bat_size_d;
            p1_y_q       <= p1_y_d;
            p2_y_q       <= p2_y_d;
            ball_x_q     <= ball_x_d;
            ball_y_q     <= ball_y_d;
            p1_bcd_q     <= p1_bcd_d;
            p2_bcd_q     <= p2_bcd_d;
            blk_cnt_q    <= blk_cnt_d;
            blink_on_q   <= blink_on_d;
            v1_q         <= v1_d;
            x1_q         <= x1_d;
            y1_q         <= y1_d;
            ball1_q      <= ball1_d;
            bat1_q       <= bat1_d;
            bat2_q       <= bat2_d;
            score1_q     <= score1_d;
            net1_q       <= net1_d;
            px_data_out  <= px_data_d;
            px_valid_out <= px_valid_d;
        end
    end

endmodule

// File: tb/tb_video_encoder_pipe.sv
module tb_video_encoder_pipe;

    localparam int CW = 11;
    localparam int SW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_start;
    logic          px_valid;
    logic [CW-1:0] x, y;
    logic          bat_size;
    logic [1:0]    mode;
    logic [SW-1:0] p1_score, p2_score;
    logic [CW-1:0] p1_y, p2_y, ball_x, ball_y;
    logic [0:0]    px_data_out;
    logic          px_valid_out;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int tag = 0;

    logic exp_q[$];
    int   iss_q[$];
    int   tag_q[$];

    video_encoder_pipe #(.BLINK_FR(2)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .px_valid(px_valid),
        .x(x), .y(y), .bat_size(bat_size), .mode(mode),
        .p1_score(p1_score), .p2_score(p2_score),
        .p1_y(p1_y), .p2_y(p2_y), .ball_x(ball_x), .ball_y(ball_y),
        .px_data_out(px_data_out), .px_valid_out(px_valid_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int id, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s (vector %0d): got %0d, expected %0d", name, id, act, exp);
        end
    endtask

    // Monitor: pop one expectation per valid output, check value and latency
    always @(negedge clk) begin : monitor
        logic e;
        int   i;
        int   t;
        if (!rst) begin
            if (px_valid_out) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", -1, 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    i = iss_q.pop_front();
                    t = tag_q.pop_front();
                    chk("pixel", t, int'(px_data_out), int'(e));
                    chk("latency", t, cyc - i, 2);
                end
            end else begin
                chk("idle_zero", -1, int'(px_data_out), 0);
            end
        end
    end

    task automatic push_exp(input logic e);
        exp_q.push_back(e);
        iss_q.push_back(cyc);
        tag_q.push_back(tag);
        tag++;
    endtask

    task automatic px(input int xv, input int yv, input logic e);
        @(negedge clk);
        frame_start = 1'b0;
        px_valid    = 1'b1;
        x           = CW'(xv);
        y           = CW'(yv);
        push_exp(e);
    endtask

    task automatic px_fs(input int xv, input int yv, input logic e);
        @(negedge clk);
        frame_start = 1'b1;
        px_valid    = 1'b1;
        x           = CW'(xv);
        y           = CW'(yv);
        push_exp(e);
    endtask

    task automatic fs();
        @(negedge clk);
        frame_start = 1'b1;
        px_valid    = 1'b0;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            frame_start = 1'b0;
            px_valid    = 1'b0;
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int w;
        rst = 1'b1; frame_start = 1'b0; px_valid = 1'b1; x = CW'(320); y = CW'(0);
        bat_size = 1'b0; mode = 2'b01; p1_score = SW'(47); p2_score = SW'(63);
        p1_y = CW'(200); p2_y = CW'(470); ball_x = CW'(300); ball_y = CW'(250);

        // 1. reset holds outputs low despite a valid net pixel
        repeat (3) @(negedge clk);
        chk("rst_valid", 0, int'(px_valid_out), 0);
        chk("rst_data", 0, int'(px_data_out), 0);
        rst = 1'b0; px_valid = 1'b0;
        // no frame_start yet: mode 00 from reset, scores "00"
        px(320, 0, 1'b1);     // net
        px(0, 0, 1'b0);       // ball at (0,0) hidden in mode 00
        px(16, 0, 1'b0);      // paddle hidden in mode 00
        px(292, 16, 1'b1);    // top segment of P1 tens digit '0'
        idle(3);

        // 2. latency and ball edges in play mode
        fs();
        px(300, 250, 1'b1);
        px(299, 250, 1'b0);
        px(308, 250, 1'b0);
        px(307, 257, 1'b1);
        px(300, 258, 1'b0);
        idle(2);

        // 3. shadow state
        ball_x = CW'(400);
        px(300, 250, 1'b1);
        px(400, 250, 1'b0);
        px_fs(300, 250, 1'b1); // same cycle as frame_start: old state
        px(400, 250, 1'b1);
        px(300, 250, 1'b0);
        idle(2);

        // 4. paddles, clipping, wrap-free sums, screen window
        px(16, 247, 1'b1);
        px(16, 248, 1'b0);
        px(23, 200, 1'b1);
        px(24, 200, 1'b0);
        px(15, 200, 1'b0);
        px(616, 470, 1'b1);
        px(623, 479, 1'b1);
        px(616, 469, 1'b0);
        px(616, 0, 1'b0);
        bat_size = 1'b1;
        fs();
        px(16, 295, 1'b1);
        px(16, 296, 1'b0);
        p2_y = CW'(2040);
        fs();
        px(616, 0, 1'b0);
        px(616, 479, 1'b0);
        ball_x = CW'(636);
        fs();
        px(639, 250, 1'b1);
        px(640, 250, 1'b0);
        px(320, 464, 1'b1);
        px(320, 480, 1'b0);
        px(319, 8, 1'b0);

        // 6. score digits 47 and 63, ball on top of a digit
        px(288, 16, 1'b1);    // '4' cell(0,0)
        px(292, 16, 1'b0);    // '4' cell(1,0)
        px(308, 16, 1'b1);    // '7' cell(1,0)
        px(304, 32, 1'b0);    // '7' cell(0,4)
        px(300, 20, 1'b0);    // gap column
        px(332, 20, 1'b0);    // '6' cell(2,1)
        px(324, 28, 1'b1);    // '6' cell(0,3)
        px(340, 28, 1'b0);    // '3' cell(0,3)
        px(348, 28, 1'b1);    // '3' cell(2,3)
        ball_x = CW'(292); ball_y = CW'(16);
        fs();
        px(292, 16, 1'b1);
        idle(4);

        // 5. blink phase with BLINK_FR=2, starting from reset
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        mode = 2'b10; ball_x = CW'(300); ball_y = CW'(250);
        bat_size = 1'b0; p1_y = CW'(200);
        fs(); px(300, 250, 1'b1);   // frame 1: lit
        fs(); px(300, 250, 1'b0);   // frame 2: dark
        fs(); px(300, 250, 1'b0);   // frame 3: dark
        fs(); px(300, 250, 1'b1);   // frame 4: lit
        mode = 2'b11;
        fs(); px(288, 16, 1'b1); px(300, 250, 1'b0);
        fs(); px(288, 16, 1'b0); px(16, 210, 1'b1); px(320, 0, 1'b1);
        fs(); px(288, 16, 1'b0);
        fs(); px(288, 16, 1'b1);
        idle(1);

        w = 0;
        while (exp_q.size() != 0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("drain", 0, exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
